// File: rtl/logictools_pkg.sv
// Shared definitions for the logictools capture and pattern blocks.
//   TRACE_WIDTH : number of shield pins traced
//   CNT_W       : width of sample counters and period dividers
//   trace_state_e : capture sequencer states
package logictools_pkg;

  localparam int unsigned TRACE_WIDTH = 20;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

endpackage

// File: rtl/trace_sample_tick.sv
// Sample-period divider: div_cnt runs 0..clk_div and tick_c marks the last
// count of each period. clear restarts the period on the next edge.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous restart of the period
//   clk_div    : period minus 1 (0 = tick every cycle)
//   tick_c     : combinational, high while div_cnt == clk_div
module trace_sample_tick #(
  parameter int unsigned CNT_W = logictools_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] clk_div,
  output logic             tick_c
);

  logic [CNT_W-1:0] div_cnt;

  // >= so a shortened period (clk_div changed) wraps instead of running to 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || (div_cnt >= clk_div)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick_c = (div_cnt == clk_div);

endmodule

// File: rtl/logic_trace_sampler.sv
// Trace capture front end: synchronizes the pins, decimates them, waits for
// a masked trigger pattern and streams a fixed number of samples out through
// a single-entry AXI4-Stream style output register.
//   clk, reset          : sampling clock, async active-high reset
//   pin_in              : raw asynchronous pin values
//   start / abort       : one-cycle pulses to arm / cancel a capture
//   clk_div             : sample period minus 1, hold stable while busy
//   sample_count        : samples emitted after trigger (0 means 1)
//   trig_mask/trig_value: masked trigger pattern
//   m_tdata/m_tvalid/m_tready/m_tlast : sample stream
//   busy, triggered, overflow, done   : status
module logic_trace_sampler
  import logictools_pkg::*;
#(
  parameter int unsigned WIDTH = TRACE_WIDTH,
  parameter int unsigned CNT_W = logictools_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] clk_div,
  input  logic [CNT_W-1:0] sample_count,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic             triggered,
  output logic             overflow,
  output logic             done
);

  // Two-flop synchronizer on the asynchronous pins
  logic [WIDTH-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // Sample period divider
  logic div_clear_c;
  logic tick_c;

  trace_sample_tick #(.CNT_W(CNT_W)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear   (div_clear_c),
    .clk_div (clk_div),
    .tick_c  (tick_c)
  );

  trace_state_e     state, state_next;
  logic [CNT_W-1:0] emit_cnt, emit_cnt_next;
  logic [CNT_W-1:0] cnt_max, cnt_max_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] mask_q, mask_next;
  logic [WIDTH-1:0] value_q, value_next;
  logic [WIDTH-1:0] tdata_next;
  logic             tvalid_next, tlast_next;
  logic             triggered_next, overflow_next, busy_next, done_next;
  logic             emit, emit_last, accept, hit;

  // Sequencer next state plus output register update
  always_comb begin
    state_next     = state;
    emit_cnt_next  = emit_cnt;
    cnt_max_next   = cnt_max;
    mask_next      = mask_q;
    value_next     = value_q;
    tdata_next     = m_tdata;
    tvalid_next    = m_tvalid;
    tlast_next     = m_tlast;
    triggered_next = triggered;
    overflow_next  = overflow;
    div_clear_c    = 1'b0;
    emit           = 1'b0;
    emit_last      = 1'b0;
    accept         = m_tvalid & m_tready;
    hit            = ((sync2 & mask_q) == (value_q & mask_q));
    cnt_inc        = emit_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next     = ARMED;
          triggered_next = 1'b0;
          overflow_next  = 1'b0;
          emit_cnt_next  = '0;
          cnt_max_next   = (sample_count == '0) ? CNT_W'(1) : sample_count;
          mask_next      = trig_mask;
          value_next     = trig_value;
          div_clear_c    = 1'b1;
        end
      end
      ARMED: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick_c && hit) begin
          // The trigger sample is itself sample 1 of the capture
          triggered_next = 1'b1;
          emit           = 1'b1;
          emit_cnt_next  = CNT_W'(1);
          emit_last      = (cnt_max == CNT_W'(1));
          state_next     = emit_last ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick_c) begin
          emit          = 1'b1;
          emit_cnt_next = cnt_inc;
          emit_last     = (cnt_inc == cnt_max);
          if (emit_last) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      tvalid_next = 1'b0;
    end

    // Load when the slot is free or draining this cycle; otherwise drop.
    // A dropped final sample still marks the held word as last so the
    // stream is always terminated.
    if (emit) begin
      if (!m_tvalid || accept) begin
        tdata_next  = sync2;
        tlast_next  = emit_last;
        tvalid_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
        if (emit_last) begin
          tlast_next = 1'b1;
        end
      end
    end

    busy_next = (state_next == ARMED) || (state_next == CAPTURE);
    done_next = (state_next == DONE);
  end

  // State, latched capture setup and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      emit_cnt  <= '0;
      cnt_max   <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      emit_cnt  <= emit_cnt_next;
      cnt_max   <= cnt_max_next;
      mask_q    <= mask_next;
      value_q   <= value_next;
      m_tdata   <= tdata_next;
      m_tvalid  <= tvalid_next;
      m_tlast   <= tlast_next;
      busy      <= busy_next;
      triggered <= triggered_next;
      overflow  <= overflow_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_logic_trace_sampler.sv
// Directed bench for logic_trace_sampler with hand-computed beat sequences.
module tb_logic_trace_sampler;

  localparam int unsigned W  = 20;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  pin_in;
  logic          start;
  logic          abort;
  logic [CW-1:0] clk_div;
  logic [CW-1:0] sample_count;
  logic [W-1:0]  trig_mask;
  logic [W-1:0]  trig_value;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          triggered;
  logic          overflow;
  logic          done;

  logic_trace_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .pin_in       (pin_in),
    .start        (start),
    .abort        (abort),
    .clk_div      (clk_div),
    .sample_count (sample_count),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .busy         (busy),
    .triggered    (triggered),
    .overflow     (overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int beat_data[$];
  bit beat_last[$];
  int beat_cyc[$];
  int done_cnt;
  int done_iter;
  int busy_fall;
  int unstable;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int beat_at(input int i);
    return (i < beat_data.size()) ? beat_data[i] : -1;
  endfunction

  function automatic int last_at(input int i);
    return (i < beat_last.size()) ? int'(beat_last[i]) : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < beat_cyc.size()) ? beat_cyc[i] : -1;
  endfunction

  // Iteration i samples just after edge s+i (s = edge that takes start) and
  // sets inputs for edge s+i+1. m_tready is low for edges s+1..s+ready_low.
  task automatic run_capture(input logic [CW-1:0] div, input logic [CW-1:0] sc,
                             input logic [W-1:0] mask, input logic [W-1:0] val,
                             input int ready_low, input int abort_at, input int n_cyc);
    logic          prev_stall;
    logic [W-1:0]  prev_data;
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    done_cnt  = 0;
    done_iter = -1;
    busy_fall = -1;
    unstable  = 0;
    clk_div      = div;
    sample_count = sc;
    trig_mask    = mask;
    trig_value   = val;
    m_tready     = (ready_low == 0);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    pin_in = pin_in + W'(1);
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      start    = 1'b0;
      abort    = (i == abort_at);
      m_tready = (i >= ready_low);
      if (prev_stall && (m_tdata !== prev_data)) unstable++;
      if (m_tvalid && m_tready) begin
        beat_data.push_back(int'(m_tdata));
        beat_last.push_back(m_tlast);
        beat_cyc.push_back(i);
      end
      if (done) begin
        done_cnt++;
        done_iter = i;
      end
      if (!busy && busy_fall < 0) busy_fall = i;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      pin_in     = pin_in + W'(1);
    end
    m_tready = 1'b1;
    abort    = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " tdata"},     32'(m_tdata),   32'd0);
    check({tag, " tvalid"},    32'(m_tvalid),  32'd0);
    check({tag, " tlast"},     32'(m_tlast),   32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " triggered"}, 32'(triggered), 32'd0);
    check({tag, " overflow"},  32'(overflow),  32'd0);
    check({tag, " done"},      32'(done),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    pin_in       = '0;
    start        = 1'b0;
    abort        = 1'b0;
    clk_div      = '0;
    sample_count = '0;
    trig_mask    = '0;
    trig_value   = '0;
    m_tready     = 1'b1;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Free-running capture: 4 consecutive samples 0..3
    pin_in = '0;
    run_capture(16'd0, 16'd4, 20'h0, 20'h0, 0, -1, 12);
    check("t2 nbeats", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2 data%0d", i), beat_at(i), i);
      check($sformatf("t2 last%0d", i), last_at(i), (i == 3) ? 1 : 0);
      check($sformatf("t2 cyc%0d", i), cyc_at(i), i + 1);
    end
    check("t2 done cnt",  done_cnt,  1);
    check("t2 done iter", done_iter, 4);
    check("t2 busy fall", busy_fall, 4);
    check("t2 triggered", 32'(triggered), 32'd1);
    check("t2 overflow",  32'(overflow),  32'd0);

    // Divided sampling with a low-nibble trigger: first tick sees 0x11 (miss)
    pin_in = 20'd14;
    run_capture(16'd3, 16'd3, 20'h0000F, 20'h00005, 0, -1, 24);
    check("t3 nbeats", 32'(beat_data.size()), 32'd3);
    check("t3 data0", beat_at(0), 32'h15);
    check("t3 data1", beat_at(1), 32'h19);
    check("t3 data2", beat_at(2), 32'h1D);
    check("t3 cyc0",  cyc_at(0), 8);
    check("t3 cyc1",  cyc_at(1), 12);
    check("t3 cyc2",  cyc_at(2), 16);
    check("t3 last",  last_at(2), 1);
    check("t3 last0", last_at(0), 0);
    check("t3 done",  done_cnt, 1);

    // Back-pressure: samples 1..4 dropped while the first word is held
    pin_in = '0;
    run_capture(16'd0, 16'd8, 20'h0, 20'h0, 5, -1, 14);
    check("t4 nbeats", 32'(beat_data.size()), 32'd4);
    check("t4 data0", beat_at(0), 0);
    check("t4 data1", beat_at(1), 5);
    check("t4 data2", beat_at(2), 6);
    check("t4 data3", beat_at(3), 7);
    check("t4 cyc0",  cyc_at(0), 5);
    check("t4 last3", last_at(3), 1);
    check("t4 last2", last_at(2), 0);
    check("t4 stable", unstable, 0);
    check("t4 overflow", 32'(overflow), 32'd1);
    check("t4 done", done_cnt, 1);
    check("t4 tvalid end", 32'(m_tvalid), 32'd0);

    // Abort two cycles after trigger; pending word drains, no done
    pin_in = '0;
    run_capture(16'd0, 16'd100, 20'h0, 20'h0, 4, 2, 10);
    check("t5 busy fall", busy_fall, 3);
    check("t5 done", done_cnt, 0);
    check("t5 nbeats", 32'(beat_data.size()), 32'd1);
    check("t5 data0", beat_at(0), 0);
    check("t5 last0", last_at(0), 0);
    check("t5 cyc0",  cyc_at(0), 4);
    check("t5 stable", unstable, 0);
    check("t5 triggered", 32'(triggered), 32'd1);
    check("t5 overflow",  32'(overflow),  32'd1);

    // New start clears the sticky flags; pattern never matches, then abort
    trig_mask  = 20'hFFFFF;
    trig_value = 20'hFFFFF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5 restart triggered", 32'(triggered), 32'd0);
    check("t5 restart overflow",  32'(overflow),  32'd0);
    check("t5 restart busy",      32'(busy),      32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5 abort idle busy", 32'(busy), 32'd0);
    check("t5 abort done",      32'(done), 32'd0);

    // Reset in the middle of a stalled capture
    pin_in       = '0;
    clk_div      = '0;
    sample_count = 16'd100;
    trig_mask    = '0;
    m_tready     = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t1 pre tvalid", 32'(m_tvalid), 32'd1);
    check("t1 pre busy",   32'(busy),     32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t1 async");
    repeat (2) begin
      @(negedge clk);
      check("t1 hold done",   32'(done),     32'd0);
      check("t1 hold tvalid", 32'(m_tvalid), 32'd0);
    end
    reset = 1'b0;

    // sample_count 0 behaves as 1
    pin_in = '0;
    run_capture(16'd0, 16'd0, 20'h0, 20'h0, 0, -1, 8);
    check("t6 nbeats", 32'(beat_data.size()), 32'd1);
    check("t6 data0",  beat_at(0), 0);
    check("t6 last0",  last_at(0), 1);
    check("t6 done",   done_cnt, 1);
    check("t6 done iter", done_iter, 1);
    check("t6 busy fall", busy_fall, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
